// File: rtl/dpram_pkg.sv
// Shared types and default widths for the dpram_gen dual-port RAM.
package dpram_pkg;

   typedef enum logic {CLEAR, RUN} dpram_state_t;

   localparam int DPRAM_DATA_W = 16;
   localparam int DPRAM_ADDR_W = 10;

endpackage

// File: rtl/dpram_clear_ctl.sv
// Clear engine for dpram_gen: walks every address once after reset or on a
// clear request, producing a write strobe/address and the busy flag.
module dpram_clear_ctl
   import dpram_pkg::*;
#(
   parameter int ADDR_W = DPRAM_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr,
   output logic              busy
);

   // One extra counter bit so the final address compare never aliases zero.
   localparam logic [ADDR_W:0] LAST = {1'b0, {ADDR_W{1'b1}}};

   dpram_state_t    state_reg, state_next;
   logic [ADDR_W:0] cnt_reg, cnt_next;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= CLEAR;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      clr_we     = 1'b0;
      busy       = 1'b0;
      case (state_reg)
         CLEAR: begin
            clr_we   = 1'b1;
            busy     = 1'b1;
            cnt_next = cnt_reg + 1'b1;
            if (cnt_reg == LAST)
               state_next = RUN;
         end
         RUN: begin
            if (clr) begin
               state_next = CLEAR;
               cnt_next   = '0;
            end
         end
         default: state_next = CLEAR;
      endcase
   end

   assign clr_addr = cnt_reg[ADDR_W-1:0];

endmodule

// File: rtl/dpram_gen.sv
// Parametrised dual-port RAM with write-first ports, port-A write priority and
// a hardware clear engine. Define DPRAM_OUTREG_EN for a second output stage.
module dpram_gen
   import dpram_pkg::*;
#(
   parameter int                ADDR_W    = DPRAM_ADDR_W,
   parameter int                DATA_W    = DPRAM_DATA_W,
   parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   input  logic              en_A,
   input  logic              en_B,
   input  logic              we_A,
   input  logic              we_B,
   input  logic [ADDR_W-1:0] addr_A,
   input  logic [ADDR_W-1:0] addr_B,
   input  logic [DATA_W-1:0] data_A,
   input  logic [DATA_W-1:0] data_B,
   output logic [DATA_W-1:0] out_A,
   output logic [DATA_W-1:0] out_B,
   output logic              busy,
   output logic              collision
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              clr_we;
   logic [ADDR_W-1:0] clr_addr;

   dpram_clear_ctl #(.ADDR_W(ADDR_W)) u_clear_ctl (
      .clk      (clk),
      .reset    (reset),
      .clr      (clr),
      .clr_we   (clr_we),
      .clr_addr (clr_addr),
      .busy     (busy)
   );

   // The clear engine borrows port A's write path while busy.
   logic              wa_en, wb_en;
   logic [ADDR_W-1:0] wa_addr;
   logic [DATA_W-1:0] wa_data;

   always_comb begin
      wa_en   = busy ? clr_we    : (en_A & we_A);
      wa_addr = busy ? clr_addr  : addr_A;
      wa_data = busy ? CLEAR_VAL : data_A;
      wb_en   = !busy && en_B && we_B && !(wa_en && (wa_addr == addr_B));
   end

   always_ff @(posedge clk) begin
      if (wb_en)
         mem[addr_B] <= data_B;
      if (wa_en)
         mem[wa_addr] <= wa_data;
   end

   logic [1:0]                   en_p, we_p;
   logic [1:0][ADDR_W-1:0]       addr_p;
   logic [1:0][DATA_W-1:0]       data_p, out_p;

   assign en_p   = {en_B, en_A};
   assign we_p   = {we_B, we_A};
   assign addr_p = {addr_B, addr_A};
   assign data_p = {data_B, data_A};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_port
         logic [DATA_W-1:0] rd_reg;

         // Memory reads see pre-edge contents, giving read-first across ports.
         always_ff @(posedge clk or posedge reset) begin
            if (reset)
               rd_reg <= '0;
            else if (!busy && en_p[gi])
               rd_reg <= we_p[gi] ? data_p[gi] : mem[addr_p[gi]];
         end

`ifdef DPRAM_OUTREG_EN
         logic [DATA_W-1:0] pipe_reg;

         always_ff @(posedge clk or posedge reset) begin
            if (reset)
               pipe_reg <= '0;
            else if (!busy)
               pipe_reg <= rd_reg;
         end

         assign out_p[gi] = pipe_reg;
`else
         assign out_p[gi] = rd_reg;
`endif
      end
   endgenerate

   assign out_A = out_p[0];
   assign out_B = out_p[1];

   // A collision on the clr edge is suppressed so the flag is never seen while busy.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         collision <= 1'b0;
      else
         collision <= !busy && !clr && en_A && we_A && en_B && we_B && (addr_A == addr_B);
   end

endmodule

// File: tb/tb_dpram_gen.sv
// Self-checking bench for dpram_gen: vector table plus scoreboard queues,
// with hand-written clear, reset and latency sequences.
module tb_dpram_gen;

`ifdef DPRAM_OUTREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif
   localparam int DEPTH = 1024;

   logic        clk = 1'b0;
   logic        reset, clr;
   logic        en_A, en_B, we_A, we_B;
   logic [9:0]  addr_A, addr_B;
   logic [15:0] data_A, data_B;
   logic [15:0] out_A, out_B;
   logic        busy, collision;

   int n_checks = 0;
   int n_fail   = 0;
   int edges    = 0;

   dpram_gen #(.ADDR_W(10), .DATA_W(16), .CLEAR_VAL(16'hA5A5)) dut (
      .clk       (clk),
      .reset     (reset),
      .clr       (clr),
      .en_A      (en_A),
      .en_B      (en_B),
      .we_A      (we_A),
      .we_B      (we_B),
      .addr_A    (addr_A),
      .addr_B    (addr_B),
      .data_A    (data_A),
      .data_B    (data_B),
      .out_A     (out_A),
      .out_B     (out_B),
      .busy      (busy),
      .collision (collision)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edges <= edges + 1;

   typedef struct {
      logic        ea, wa;
      logic [9:0]  aa;
      logic [15:0] da;
      logic        eb, wb;
      logic [9:0]  ab;
      logic [15:0] db;
      logic        ca, cb;
      logic [15:0] xa, xb;
      logic        xc;
   } vec_t;

   typedef struct {
      int          due;
      int          port;
      logic [15:0] exp;
   } sb_t;

   typedef struct {
      int   due;
      logic exp;
   } cb_t;

   sb_t qd[$];
   cb_t qc[$];
   vec_t vecs[14];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end else
         $display("ok   %s: %0h (t=%0t)", name, got, $time);
   endtask

   always @(negedge clk) begin : mon
      sb_t it;
      cb_t ic;
      while (qd.size() > 0 && qd[0].due <= edges) begin
         it = qd.pop_front();
         if (it.due < edges)
            check("sb_late", it.due, edges);
         else if (it.port == 0)
            check("out_A", out_A, it.exp);
         else
            check("out_B", out_B, it.exp);
      end
      while (qc.size() > 0 && qc[0].due <= edges) begin
         ic = qc.pop_front();
         if (ic.due < edges)
            check("sbc_late", ic.due, edges);
         else
            check("collision", collision, ic.exp);
      end
   end

   task automatic idle();
      en_A = 1'b0; we_A = 1'b0; addr_A = '0; data_A = '0;
      en_B = 1'b0; we_B = 1'b0; addr_B = '0; data_B = '0;
   endtask

   task automatic apply(input vec_t v);
      int k;
      en_A = v.ea; we_A = v.wa; addr_A = v.aa; data_A = v.da;
      en_B = v.eb; we_B = v.wb; addr_B = v.ab; data_B = v.db;
      @(posedge clk);
      #1;
      k = edges;
      if (v.ca) qd.push_back('{k + LAT - 1, 0, v.xa});
      if (v.cb) qd.push_back('{k + LAT - 1, 1, v.xb});
      qc.push_back('{k, v.xc});
   endtask

   task automatic read2(input logic [9:0] a, input logic [9:0] b, input logic [15:0] xa,
                        input logic [15:0] xb);
      apply('{1'b1, 1'b0, a, 16'h0, 1'b1, 1'b0, b, 16'h0, 1'b1, 1'b1, xa, xb, 1'b0});
   endtask

   task automatic wait_clear(input string name, input int exp_cycles);
      int cnt;
      int coll_seen;
      cnt = 0;
      coll_seen = 0;
      while (busy && cnt < 5000) begin
         @(posedge clk);
         #1;
         cnt++;
         if (busy && collision) coll_seen++;
      end
      check(name, cnt, exp_cycles);
      check({name, "_coll"}, coll_seen, 0);
   endtask

   initial begin
      int lat;

      vecs[0]  = '{1,1,10'd5,  16'h1234, 1,1,10'd900,16'hBEEF, 1,1,16'h1234,16'hBEEF,0};
      vecs[1]  = '{1,0,10'd5,  16'h0,    1,0,10'd900,16'h0,    1,1,16'h1234,16'hBEEF,0};
      vecs[2]  = '{1,0,10'd900,16'h0,    1,0,10'd5,  16'h0,    1,1,16'hBEEF,16'h1234,0};
      vecs[3]  = '{1,1,10'd7,  16'h1111, 1,1,10'd7,  16'h2222, 1,1,16'h1111,16'h2222,1};
      vecs[4]  = '{1,0,10'd7,  16'h0,    0,0,10'd0,  16'h0,    1,1,16'h1111,16'h2222,0};
      vecs[5]  = '{1,1,10'd3,  16'h0000, 0,0,10'd0,  16'h0,    1,1,16'h0000,16'h2222,0};
      vecs[6]  = '{1,1,10'd3,  16'h0F0F, 1,0,10'd3,  16'h0,    1,1,16'h0F0F,16'h0000,0};
      vecs[7]  = '{1,0,10'd7,  16'h0,    1,0,10'd3,  16'h0,    1,1,16'h1111,16'h0F0F,0};
      vecs[8]  = '{1,0,10'd5,  16'h0,    1,0,10'd5,  16'h0,    1,1,16'h1234,16'h1234,0};
      vecs[9]  = '{1,0,10'd7,  16'h0,    1,1,10'd7,  16'h3333, 1,1,16'h1111,16'h3333,0};
      vecs[10] = '{1,1,10'd10, 16'hAAAA, 1,1,10'd11, 16'hBBBB, 1,1,16'hAAAA,16'hBBBB,0};
      vecs[11] = '{1,0,10'd11, 16'h0,    1,0,10'd10, 16'h0,    1,1,16'hBBBB,16'hAAAA,0};
      vecs[12] = '{0,1,10'd5,  16'hFFFF, 1,0,10'd5,  16'h0,    1,1,16'hBBBB,16'h1234,0};
      vecs[13] = '{1,0,10'd7,  16'h0,    1,0,10'd5,  16'h0,    1,1,16'h3333,16'h1234,0};

      // Reset state and first clear.
      reset = 1'b1;
      clr   = 1'b0;
      idle();
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_A", out_A, 16'h0);
      check("rst_out_B", out_B, 16'h0);
      check("rst_busy", busy, 1'b1);
      check("rst_coll", collision, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      wait_clear("clear_len", DEPTH);

      for (int i = 0; i < 16; i++)
         read2(10'(i), 10'(15 - i), 16'hA5A5, 16'hA5A5);
      read2(10'd1023, 10'd512, 16'hA5A5, 16'hA5A5);

      for (int i = 0; i < 14; i++)
         apply(vecs[i]);
      idle();
      repeat (3) @(posedge clk);

      // Clear request with accesses on the clr edge and during busy.
      apply('{1,1,10'd20,16'h1357, 1,1,10'd23,16'h7531, 1,1,16'h1357,16'h7531,0});
      clr = 1'b1;
      apply('{1,1,10'd21,16'h2468, 1,1,10'd22,16'h8642, 0,0,16'h0,16'h0,0});
      clr = 1'b0;
      check("clr_busy", busy, 1'b1);
      en_A = 1'b1; we_A = 1'b1; addr_A = 10'd30; data_A = 16'hDEAD;
      en_B = 1'b1; we_B = 1'b1; addr_B = 10'd31; data_B = 16'hBEEF;
      wait_clear("clr_len", DEPTH);
      idle();
      check("hold_A", out_A, (LAT == 1) ? 16'h2468 : 16'h1357);
      check("hold_B", out_B, (LAT == 1) ? 16'h8642 : 16'h7531);
      read2(10'd20, 10'd21, 16'hA5A5, 16'hA5A5);
      read2(10'd22, 10'd23, 16'hA5A5, 16'hA5A5);
      read2(10'd30, 10'd31, 16'hA5A5, 16'hA5A5);

      // Read latency measurement.
      apply('{1,1,10'd50,16'hC3C3, 0,0,10'd0,16'h0, 1,0,16'hC3C3,16'h0,0});
      apply('{1,1,10'd51,16'h3C3C, 0,0,10'd0,16'h0, 1,0,16'h3C3C,16'h0,0});
      idle();
      repeat (3) @(posedge clk);
      #1;
      en_A = 1'b1; we_A = 1'b0; addr_A = 10'd50;
      @(posedge clk);
      #1;
      idle();
      lat = 1;
      while (out_A !== 16'hC3C3 && lat < 5) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("read_latency", lat, LAT);

      // Reset in the middle of a clear at cnt=9.
      clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("midclr_busy", busy, 1'b1);
      check("midclr_out_A", out_A, 16'h0);
      check("midclr_out_B", out_B, 16'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      wait_clear("midclr_len", DEPTH);
      read2(10'd50, 10'd7, 16'hA5A5, 16'hA5A5);
      idle();
      repeat (4) @(posedge clk);
      #1;
      check("sb_drain", qd.size() + qc.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
